// File: rtl/core_pkg.sv
// Core-wide types shared by the front end: fetch bundle width and the queued fetch entry.
package core_pkg;

    localparam int CORE_XLEN   = 32;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] instr;
    } fetch_entry_t;

    // Entries actually consumed: slot 1 counts only alongside slot 0, and only where valid.
    function automatic logic [1:0] pop_count(input logic [1:0] accept, input logic [1:0] valid);
        logic take0;
        logic take1;
        take0 = accept[0] & valid[0];
        take1 = take0 & accept[1] & valid[1];
        return {1'b0, take0} + {1'b0, take1};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer: pushes a pair of entries, pops 0..2 from the head, flushes to empty.
module fetch_queue
    import core_pkg::*;
#(
    parameter int FQ_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push0_i,
    input  fetch_entry_t               push1_i,
    input  logic [1:0]                 pop_i,
    output logic [1:0]                 valid_o,
    output fetch_entry_t               head0_o,
    output fetch_entry_t               head1_o,
    output logic [$clog2(FQ_DEPTH):0]  count_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [FQ_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head1_s;
    logic [PW-1:0] tail1_s;
    logic [1:0]    pop_s;

    assign head1_s = head_q + PW'(1);
    assign tail1_s = tail_q + PW'(1);
    assign valid_o = {count_q >= CW'(2), count_q >= CW'(1)};
    assign pop_s   = pop_count(pop_i, valid_o);
    assign count_o = count_q;

    // Decode only ever sees entries present at cycle start; empty slots read as zero.
    assign head0_o = valid_o[0] ? mem_q[head_q]  : '0;
    assign head1_o = valid_o[1] ? mem_q[head1_s] : '0;

    // Pointer and occupancy next-state; flush overrides any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_s);
            tail_d  = push_i ? (tail_q + PW'(2)) : tail_q;
            count_d = count_q + (push_i ? CW'(2) : CW'(0)) - CW'(pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; a response pair lands at tail and tail+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[tail_q]  <= push0_i;
            mem_q[tail1_s] <= push1_i;
        end else begin
            mem_q[tail_q]  <= mem_q[tail_q];
        end
    end

endmodule

// File: rtl/fetch_unit_checker.sv
// Simulation checks for the fetch stage: queue never overfills, responses echo the requested PC.
module fetch_unit_checker #(
    parameter int XLEN     = 32,
    parameter int FQ_DEPTH = 8,
    parameter int CW       = $clog2(FQ_DEPTH) + 1
) (
    input logic            clk,
    input logic            reset,
    input logic [CW-1:0]   count_i,
    input logic            imem_valid_i,
    input logic            squash_i,
    input logic [XLEN-1:0] resp_pc_i,
    input logic [XLEN-1:0] exp_pc_i
);

    a_fq_no_overflow: assert property (@(posedge clk) disable iff (reset)
        count_i <= CW'(FQ_DEPTH));

    a_resp_pc_match: assert property (@(posedge clk) disable iff (reset)
        (imem_valid_i && !squash_i) |-> (resp_pc_i == exp_pc_i));

endmodule

// File: rtl/fetch_unit.sv
// 2-wide fetch stage: owns the PC, issues paired ROM reads under a queue credit,
// buffers responses and presents up to two in-order entries to decode.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter int              FQ_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_ren,
    output logic [XLEN-1:0]      imem_addr0,
    output logic [XLEN-1:0]      imem_addr1,
    input  logic                 imem_valid,
    input  logic [XLEN-1:0]      imem_rdata0,
    input  logic [XLEN-1:0]      imem_rdata1,
    input  logic [1:0][XLEN-1:0] imem_pc,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [1:0]           fq_valid,
    output logic [XLEN-1:0]      fq_instr0,
    output logic [XLEN-1:0]      fq_instr1,
    output logic [XLEN-1:0]      fq_pc0,
    output logic [XLEN-1:0]      fq_pc1,
    input  logic [1:0]           dec_accept
);

    localparam int              CW          = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]     ISSUE_LIMIT = (CW+1)'(FQ_DEPTH - FETCH_WIDTH);
    localparam logic [XLEN-1:0] WORD_BYTES  = XLEN'(4);
    localparam logic [XLEN-1:0] PAIR_BYTES  = XLEN'(8);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            squash_q, squash_d;
    logic [CW-1:0]   count_s;
    logic [CW:0]     used_s;
    logic            issue_s;
    logic            push_s;
    logic [1:0]      valid_s;
    fetch_entry_t    push0_s, push1_s, head0_s, head1_s;

    // Credit counts queued entries plus the pair that is already on its way back.
    assign used_s  = {1'b0, count_s} + {{(CW-1){1'b0}}, inflight_q, 1'b0};
    assign issue_s = !reset && !redirect_valid && (used_s <= ISSUE_LIMIT);
    assign push_s  = imem_valid && !squash_q;
    assign push0_s = '{pc: imem_pc[0], instr: imem_rdata0};
    assign push1_s = '{pc: imem_pc[1], instr: imem_rdata1};

    assign imem_ren   = issue_s;
    assign imem_addr0 = reset ? '0 : pc_q;
    assign imem_addr1 = reset ? '0 : (pc_q + WORD_BYTES);

    assign fq_valid  = valid_s;
    assign fq_instr0 = head0_s.instr;
    assign fq_pc0    = head0_s.pc;
    assign fq_instr1 = head1_s.instr;
    assign fq_pc1    = head1_s.pc;

    // PC, inflight and squash next-state; a redirect overrides any issue.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        squash_d   = 1'b0;
        if (redirect_valid) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            squash_d = inflight_q;
        end else if (issue_s) begin
            pc_d       = pc_q + PAIR_BYTES;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (push_s),
        .push0_i (push0_s),
        .push1_i (push1_s),
        .pop_i   (dec_accept),
        .valid_o (valid_s),
        .head0_o (head0_s),
        .head1_o (head1_s),
        .count_o (count_s)
    );

    fetch_unit_checker #(
        .XLEN     (XLEN),
        .FQ_DEPTH (FQ_DEPTH),
        .CW       (CW)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .count_i      (count_s),
        .imem_valid_i (imem_valid),
        .squash_i     (squash_q),
        .resp_pc_i    (imem_pc[0]),
        .exp_pc_i     (req_pc_q)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based reference model with a 1-cycle ROM.
module tb_fetch_unit;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 imem_ren;
    logic [XLEN-1:0]      imem_addr0, imem_addr1;
    logic                 imem_valid;
    logic [XLEN-1:0]      imem_rdata0, imem_rdata1;
    logic [1:0][XLEN-1:0] imem_pc;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic [1:0]           fq_valid;
    logic [XLEN-1:0]      fq_instr0, fq_instr1, fq_pc0, fq_pc1;
    logic [1:0]           dec_accept;

    fetch_unit #(
        .XLEN     (XLEN),
        .FQ_DEPTH (FQ_DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_ren       (imem_ren),
        .imem_addr0     (imem_addr0),
        .imem_addr1     (imem_addr1),
        .imem_valid     (imem_valid),
        .imem_rdata0    (imem_rdata0),
        .imem_rdata1    (imem_rdata1),
        .imem_pc        (imem_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_valid       (fq_valid),
        .fq_instr0      (fq_instr0),
        .fq_instr1      (fq_instr1),
        .fq_pc0         (fq_pc0),
        .fq_pc1         (fq_pc1),
        .dec_accept     (dec_accept)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_infl;
    bit          m_squash;
    bit          rom_pend;
    logic [31:0] rom_a0, rom_a1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic [1:0] acc, input logic rv, input logic [31:0] rpc);
        int   free;
        bit   exp_ren;
        int   npop;
        ent_t e;
        imem_valid     = rom_pend;
        imem_pc[0]     = rom_pend ? rom_a0 : 32'h0;
        imem_pc[1]     = rom_pend ? rom_a1 : 32'h0;
        imem_rdata0    = rom_pend ? rom_word(rom_a0) : 32'h0;
        imem_rdata1    = rom_pend ? rom_word(rom_a1) : 32'h0;
        dec_accept     = acc;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        free    = FQ_DEPTH - mq.size() - 2 * int'(m_infl);
        exp_ren = !rv && (free >= 2);
        check_eq("imem_ren", 64'(imem_ren), 64'(exp_ren));
        check_eq("imem_addr0", 64'(imem_addr0), 64'(m_pc));
        check_eq("imem_addr1", 64'(imem_addr1), 64'(m_pc + 32'd4));
        check_eq("fq_valid", 64'(fq_valid), 64'({mq.size() >= 2, mq.size() >= 1}));
        if (mq.size() >= 1) begin
            check_eq("fq_pc0", 64'(fq_pc0), 64'(mq[0].pc));
            check_eq("fq_instr0", 64'(fq_instr0), 64'(mq[0].instr));
        end
        if (mq.size() >= 2) begin
            check_eq("fq_pc1", 64'(fq_pc1), 64'(mq[1].pc));
            check_eq("fq_instr1", 64'(fq_instr1), 64'(mq[1].instr));
        end
        rom_pend = imem_ren;
        rom_a0   = imem_addr0;
        rom_a1   = imem_addr1;
        if (rv) begin
            mq.delete();
            m_squash = m_infl;
            m_infl   = 1'b0;
            m_pc     = rpc & ~32'h3;
        end else begin
            npop = 0;
            if (acc[0] && mq.size() >= 1) npop = (acc[1] && mq.size() >= 2) ? 2 : 1;
            for (int k = 0; k < npop; k++) void'(mq.pop_front());
            if (imem_valid && !m_squash) begin
                e.pc = imem_pc[0]; e.instr = imem_rdata0; mq.push_back(e);
                e.pc = imem_pc[1]; e.instr = imem_rdata1; mq.push_back(e);
            end
            m_squash = 1'b0;
            m_infl   = exp_ren;
            if (exp_ren) m_pc = m_pc + 32'd8;
        end
        @(negedge clk);
    endtask

    // Asserts reset (possibly mid-cycle), checks the immediate output state, releases on a falling edge.
    task automatic apply_reset();
        reset          = 1'b1;
        dec_accept     = 2'b00;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_valid     = 1'b0;
        imem_rdata0    = 32'h0;
        imem_rdata1    = 32'h0;
        imem_pc        = '0;
        rom_pend       = 1'b0;
        mq.delete();
        m_pc     = 32'h0;
        m_infl   = 1'b0;
        m_squash = 1'b0;
        #1;
        check_eq("rst_imem_ren", 64'(imem_ren), 64'h0);
        check_eq("rst_imem_addr0", 64'(imem_addr0), 64'h0);
        check_eq("rst_imem_addr1", 64'(imem_addr1), 64'h0);
        check_eq("rst_fq_valid", 64'(fq_valid), 64'h0);
        check_eq("rst_fq_data", {fq_instr0 | fq_instr1, fq_pc0 | fq_pc1}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] acc_tbl [3];
        acc_tbl[0] = 2'b00;
        acc_tbl[1] = 2'b01;
        acc_tbl[2] = 2'b11;

        apply_reset();
        for (int i = 0; i < 16; i++) step(2'b11, 1'b0, 32'h0);

        apply_reset();
        for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)  step(2'b11, 1'b0, 32'h0);

        apply_reset();
        for (int i = 0; i < 24; i++) step(2'b01, 1'b0, 32'h0);

        apply_reset();
        step(2'b11, 1'b0, 32'h0);
        step(2'b11, 1'b1, 32'h103);
        for (int i = 0; i < 8; i++) step(2'b11, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 32'h0);
        step(2'b11, 1'b1, 32'h200);
        for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 32'h0);

        step(2'b01, 1'b1, 32'h300);
        step(2'b01, 1'b1, 32'h404);
        for (int i = 0; i < 6; i++) step(2'b01, 1'b0, 32'h0);

        step(2'b11, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step(2'b11, 1'b0, 32'h0);

        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 32'h0);
        #2;
        apply_reset();
        for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 32'h0);

        for (int i = 0; i < 500; i++) begin
            step(acc_tbl[$urandom_range(0, 2)], ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
